// File: rtl/incdec_seq_pkg.sv
// Shared definitions for the incdec sequencer: state encoding, default widths
// and flag bit positions.
package incdec_seq_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_FLAGSIZE = 8;

    localparam int DEF_FLAG_S = 7;
    localparam int DEF_FLAG_Z = 6;
    localparam int DEF_FLAG_A = 4;
    localparam int DEF_FLAG_P = 2;
    localparam int DEF_FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/incdec_seq_unit.sv
// Combinational INR/DCR-style increment/decrement unit with 8080-style flags.
// The carry/borrow out of the top bit is exported for multi-byte chaining.
module incdec_seq_unit
    import incdec_seq_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int FLAGSIZE = DEF_FLAGSIZE,
    parameter int FLAG_S   = DEF_FLAG_S,
    parameter int FLAG_Z   = DEF_FLAG_Z,
    parameter int FLAG_A   = DEF_FLAG_A,
    parameter int FLAG_P   = DEF_FLAG_P,
    parameter int FLAG_C   = DEF_FLAG_C
) (
    input  logic [DATASIZE-1:0] a,
    input  logic                dec,
    output logic [DATASIZE-1:0] s,
    output logic                c,
    output logic [FLAGSIZE-1:0] f
);

    localparam logic [DATASIZE:0] ONE = {{DATASIZE{1'b0}}, 1'b1};

    logic [DATASIZE:0] t;
    logic [4:0]        nib;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        t   = dec ? ({1'b0, a} - ONE) : ({1'b0, a} + ONE);
        nib = dec ? ({1'b0, a[3:0]} - 5'd1) : ({1'b0, a[3:0]} + 5'd1);
        f         = '0;
        f[FLAG_S] = t[DATASIZE-1];
        f[FLAG_Z] = (t[DATASIZE-1:0] == '0);
        f[FLAG_A] = nib[4];
        f[FLAG_P] = ~^t[DATASIZE-1:0];
        f[FLAG_C] = t[DATASIZE];
    end

    assign s = t[DATASIZE-1:0];
    assign c = t[DATASIZE];

endmodule

// File: rtl/incdec_seq.sv
// Round-robin sequencer sharing one incdec unit between two requesters;
// 16-bit pair ops run as a low-byte pass followed by a high-byte pass.
module incdec_seq
    import incdec_seq_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int FLAGSIZE = DEF_FLAGSIZE,
    parameter int FLAG_S   = DEF_FLAG_S,
    parameter int FLAG_Z   = DEF_FLAG_Z,
    parameter int FLAG_A   = DEF_FLAG_A,
    parameter int FLAG_P   = DEF_FLAG_P,
    parameter int FLAG_C   = DEF_FLAG_C
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReq0,
    input  logic                  iDec0,
    input  logic                  iWide0,
    input  logic [2*DATASIZE-1:0] iA0,
    input  logic                  iReq1,
    input  logic                  iDec1,
    input  logic                  iWide1,
    input  logic [2*DATASIZE-1:0] iA1,
    output logic [1:0]            oAck,
    output logic                  oValid,
    output logic                  oGnt,
    output logic [2*DATASIZE-1:0] oS,
    output logic [FLAGSIZE-1:0]   oF,
    output logic                  oFV,
    output logic                  oBusy
);

    localparam int W = 2 * DATASIZE;

    state_t state, state_nxt;

    logic [W-1:0]        op_a;
    logic                op_dec;
    logic                op_wide;
    logic                owner;
    logic                ptr;
    logic [DATASIZE-1:0] lo_res;
    logic                lo_carry;
    logic [W-1:0]        s_q;
    logic [FLAGSIZE-1:0] f_q;
    logic                fv_q;
    logic                gnt0, gnt1;

    logic [DATASIZE-1:0] u_a;
    logic [DATASIZE-1:0] u_s;
    logic                u_c;
    logic [FLAGSIZE-1:0] u_f;

    assign u_a = (state == HI) ? op_a[W-1:DATASIZE] : op_a[DATASIZE-1:0];

    incdec_seq_unit #(
        .DATASIZE (DATASIZE),
        .FLAGSIZE (FLAGSIZE),
        .FLAG_S   (FLAG_S),
        .FLAG_Z   (FLAG_Z),
        .FLAG_A   (FLAG_A),
        .FLAG_P   (FLAG_P),
        .FLAG_C   (FLAG_C)
    ) u_unit (
        .a   (u_a),
        .dec (op_dec),
        .s   (u_s),
        .c   (u_c),
        .f   (u_f)
    );

    // ptr holds the last requester served; on contention the other one wins.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (!iReset) begin
                    gnt0 = iReq0 && (!iReq1 || ptr);
                    gnt1 = iReq1 && (!iReq0 || !ptr);
                end
                if (gnt0 || gnt1)
                    state_nxt = LO;
            end
            LO:      state_nxt = op_wide ? HI : DONE;
            HI:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge iClock) begin
        if (iReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            op_a     <= '0;
            op_dec   <= 1'b0;
            op_wide  <= 1'b0;
            owner    <= 1'b0;
            ptr      <= 1'b1;
            lo_res   <= '0;
            lo_carry <= 1'b0;
            s_q      <= '0;
            f_q      <= '0;
            fv_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_a    <= gnt1 ? iA1 : iA0;
                        op_dec  <= gnt1 ? iDec1 : iDec0;
                        op_wide <= gnt1 ? iWide1 : iWide0;
                        owner   <= gnt1;
                        ptr     <= gnt1;
                    end
                end
                LO: begin
                    lo_res   <= u_s;
                    lo_carry <= u_c;
                    if (!op_wide) begin
                        s_q  <= {{DATASIZE{1'b0}}, u_s};
                        f_q  <= u_f;
                        fv_q <= 1'b1;
                    end
                end
                HI: begin
                    // High byte only moves when the low byte carried/borrowed out.
                    s_q  <= {(lo_carry ? u_s : op_a[W-1:DATASIZE]), lo_res};
                    f_q  <= '0;
                    fv_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign oAck   = {gnt1, gnt0};
    assign oValid = (state == DONE);
    assign oGnt   = (state == DONE) && owner;
    assign oS     = s_q;
    assign oF     = f_q;
    assign oFV    = fv_q;
    assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_incdec_seq.sv
// Directed bench for incdec_seq: expected results are queued at accept time
// from a behavioural model and compared when oValid appears.
module tb_incdec_seq;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iReq0, iDec0, iWide0;
    logic [15:0] iA0;
    logic        iReq1, iDec1, iWide1;
    logic [15:0] iA1;
    logic [1:0]  oAck;
    logic        oValid, oGnt, oFV, oBusy;
    logic [15:0] oS;
    logic [7:0]  oF;

    incdec_seq dut (
        .iClock (iClock),
        .iReset (iReset),
        .iReq0  (iReq0),
        .iDec0  (iDec0),
        .iWide0 (iWide0),
        .iA0    (iA0),
        .iReq1  (iReq1),
        .iDec1  (iDec1),
        .iWide1 (iWide1),
        .iA1    (iA1),
        .oAck   (oAck),
        .oValid (oValid),
        .oGnt   (oGnt),
        .oS     (oS),
        .oF     (oF),
        .oFV    (oFV),
        .oBusy  (oBusy)
    );

    always #5 iClock = ~iClock;

    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    typedef struct {
        logic        gnt;
        logic [15:0] s;
        logic [7:0]  f;
        logic        fv;
        logic        wide;
        int          ack_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic n, input logic dec, input logic wide,
                                   input logic [15:0] a);
        exp_t       e;
        logic [7:0] r;
        e.gnt = n; e.wide = wide; e.ack_cyc = cyc; e.f = 8'h00;
        if (wide) begin
            e.s  = dec ? a - 16'd1 : a + 16'd1;
            e.fv = 1'b0;
        end else begin
            r      = dec ? a[7:0] - 8'd1 : a[7:0] + 8'd1;
            e.s    = {8'h00, r};
            e.fv   = 1'b1;
            e.f[7] = r[7];
            e.f[6] = (r == 8'h00);
            e.f[4] = dec ? (a[3:0] == 4'h0) : (a[3:0] == 4'hF);
            e.f[2] = ~^r;
            e.f[0] = dec ? (a[7:0] == 8'h00) : (a[7:0] == 8'hFF);
        end
        return e;
    endfunction

    task automatic to_high();
        @(posedge iClock); #1;
    endtask

    task automatic drive(input logic n, input logic dec, input logic wide, input logic [15:0] a);
        if (n) begin iDec1 = dec; iWide1 = wide; iA1 = a; iReq1 = 1'b1; end
        else   begin iDec0 = dec; iWide0 = wide; iA0 = a; iReq0 = 1'b1; end
    endtask

    task automatic release_req(input logic n);
        @(posedge iClock); #1;
        if (n) iReq1 = 1'b0; else iReq0 = 1'b0;
    endtask

    // Checks the current low phase first so an ack right after DONE is not missed.
    task automatic wait_ack(input logic n);
        bit got = 0;
        if (iClock) @(negedge iClock);
        for (int i = 0; i < 20 && !got; i++) begin
            if (oAck != 2'b00) begin
                check(n ? "ack_req1" : "ack_req0", {30'd0, oAck}, n ? 32'd2 : 32'd1);
                sb.push_back(n ? model(1'b1, iDec1, iWide1, iA1) : model(1'b0, iDec0, iWide0, iA0));
                got = 1;
            end else begin
                @(negedge iClock);
            end
        end
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_valid();
        bit   got = 0;
        exp_t e;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge iClock);
            if (oBusy) check("no_ack_busy", {30'd0, oAck}, 32'd0);
            if (oValid) begin
                got = 1;
                check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("gnt",     {31'd0, oGnt}, {31'd0, e.gnt});
                    check("result",  {16'd0, oS},   {16'd0, e.s});
                    check("flags",   {24'd0, oF},   {24'd0, e.f});
                    check("fv",      {31'd0, oFV},  {31'd0, e.fv});
                    check("latency", cyc - e.ack_cyc, e.wide ? 32'd3 : 32'd2);
                    last_s = e.s;
                end
            end
        end
        check("valid_seen", {31'd0, got}, 32'd1);
        @(negedge iClock);
        check("valid_pulse", {31'd0, oValid}, 32'd0);
    endtask

    task automatic run_single(input logic n, input logic dec, input logic wide, input logic [15:0] a);
        to_high();
        drive(n, dec, wide, a);
        wait_ack(n);
        release_req(n);
        wait_valid();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   {30'd0, oAck},   32'd0);
        check({tag, "_valid"}, {31'd0, oValid}, 32'd0);
        check({tag, "_gnt"},   {31'd0, oGnt},   32'd0);
        check({tag, "_s"},     {16'd0, oS},     32'd0);
        check({tag, "_f"},     {24'd0, oF},     32'd0);
        check({tag, "_fv"},    {31'd0, oFV},    32'd0);
        check({tag, "_busy"},  {31'd0, oBusy},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;
        iReset = 1'b1;
        iReq0 = 0; iDec0 = 0; iWide0 = 0; iA0 = '0;
        iReq1 = 0; iDec1 = 0; iWide1 = 0; iA1 = '0;
        last_s = '0;
        repeat (3) @(posedge iClock);
        #1 iReset = 1'b0;
        @(negedge iClock);
        check_all_zero("reset");

        // 8-bit ops
        run_single(1'b0, 1'b0, 1'b0, 16'h007F);
        @(negedge iClock);
        check("s_hold", {16'd0, oS}, {16'd0, last_s});
        run_single(1'b1, 1'b1, 1'b0, 16'h0001);
        run_single(1'b1, 1'b0, 1'b0, 16'h00FF);
        run_single(1'b0, 1'b1, 1'b0, 16'h5A00);

        // 16-bit ops
        run_single(1'b0, 1'b0, 1'b1, 16'h00FF);
        run_single(1'b1, 1'b0, 1'b1, 16'h1234);
        run_single(1'b0, 1'b1, 1'b1, 16'h0000);
        run_single(1'b1, 1'b0, 1'b1, 16'hFFFF);
        run_single(1'b0, 1'b1, 1'b1, 16'h1200);

        // Both requesters held from reset: order 0, 1, 0, 1
        to_high();
        iReset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0010);
        drive(1'b1, 1'b1, 1'b1, 16'h0100);
        @(negedge iClock);
        check("ack_in_reset", {30'd0, oAck}, 32'd0);
        to_high();
        iReset = 1'b0;
        wait_ack(1'b0);
        wait_valid();
        wait_ack(1'b1);
        wait_valid();
        wait_ack(1'b0);
        wait_valid();
        wait_ack(1'b1);
        @(posedge iClock); #1;
        iReq0 = 1'b0; iReq1 = 1'b0;
        wait_valid();

        // Requester 1 raised mid-op is not acked until IDLE
        to_high();
        drive(1'b0, 1'b1, 1'b1, 16'h1200);
        wait_ack(1'b0);
        release_req(1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0041);
        wait_valid();
        wait_ack(1'b1);
        release_req(1'b1);
        wait_valid();

        // Reset during the HI pass abandons the op
        to_high();
        drive(1'b0, 1'b0, 1'b1, 16'h12FF);
        wait_ack(1'b0);
        release_req(1'b0);
        @(posedge iClock); #1;
        check("in_hi_busy", {31'd0, oBusy}, 32'd1);
        iReset = 1'b1;
        @(posedge iClock); #1;
        iReset = 1'b0;
        @(negedge iClock);
        check_all_zero("abort");
        sb.delete();
        saw_valid = 0;
        repeat (4) begin
            @(negedge iClock);
            if (oValid) saw_valid = 1;
        end
        check("abort_no_valid", {31'd0, saw_valid}, 32'd0);

        to_high();
        drive(1'b0, 1'b0, 1'b0, 16'h000F);
        drive(1'b1, 1'b0, 1'b1, 16'hABFF);
        wait_ack(1'b0);
        release_req(1'b0);
        wait_valid();
        wait_ack(1'b1);
        release_req(1'b1);
        wait_valid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
